// File: rtl/trace_cmd_feeder.sv
// trace_cmd_feeder
// Front end of the cache model: converts raw trace records into cache
// commands, drops illegal trace codes, buffers legal commands in a small
// first-word-fall-through FIFO and hands them to the cache over a
// valid/ready handshake. Signals done once end-of-trace has been seen and
// every buffered command has been consumed.
module trace_cmd_feeder #(
    parameter int DEPTH  = 4,   // FIFO entries, power of two, >= 2
    parameter int ADDR_W = 32,  // address width
    parameter int CNT_W  = 32   // statistics counter width
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_code,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_eof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_cmd,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]  rec_cnt,
    output logic [CNT_W-1:0]  bad_cnt,
    output logic              done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        CMD_READ       = 3'd0,
        CMD_WRITE      = 3'd1,
        CMD_I_FETCH    = 3'd2,
        CMD_L2_INVAL   = 3'd3,
        CMD_L2_DATA_RQ = 3'd4,
        CMD_CLR        = 3'd5,
        CMD_PRINT      = 3'd6
    } cmd_t;

    typedef struct packed {
        cmd_t              cmd;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        last_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    state_t        state;
    state_t        state_next;
    logic          live_q;
    logic          legal;
    cmd_t          in_cmd;
    logic          accept;
    logic          push;
    logic          bad;
    logic          pop;

    // Trace code to cache command translation; unmapped codes are illegal.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        legal  = 1'b1;
        in_cmd = CMD_READ;
        case (in_code)
            4'd0:    in_cmd = CMD_READ;
            4'd1:    in_cmd = CMD_WRITE;
            4'd2:    in_cmd = CMD_I_FETCH;
            4'd3:    in_cmd = CMD_L2_INVAL;
            4'd4:    in_cmd = CMD_L2_DATA_RQ;
            4'd8:    in_cmd = CMD_CLR;
            4'd9:    in_cmd = CMD_PRINT;
            default: legal  = 1'b0;
        endcase
    end

    // Handshake decode. in_ready depends only on registered state, so a pop
    // in the same cycle never opens a slot in a full FIFO. live_q holds
    // in_ready low through reset and until the first edge after release.
    assign in_ready  = live_q && (state == ST_RUN) && (count < DEPTH_C);
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign bad       = accept && !legal;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign done      = (state == ST_DONE);

    // Head of the FIFO falls through while valid; otherwise the last popped
    // command stays on the bus (zero after reset).
    assign out_cmd  = out_valid ? mem[rd_ptr].cmd  : last_q.cmd;
    assign out_addr = out_valid ? mem[rd_ptr].addr : last_q.addr;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // FIFO storage.
    // NOTE: the entry array has no reset; a slot is only ever read after it
    // has been written, and out_cmd/out_addr come from last_q when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{cmd: in_cmd, addr: in_addr};
        end
    end

    // Pointers, occupancy, last-popped holding register and the reset gate.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
            count  <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                last_q <= mem[rd_ptr];
            end
        end
    end

    // Saturating statistics for accepted legal and dropped illegal records.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_cnt <= '0;
            bad_cnt <= '0;
        end else begin
            if (push && (rec_cnt != '1)) begin
                rec_cnt <= rec_cnt + CNT_W'(1);
            end
            if (bad && (bad_cnt != '1)) begin
                bad_cnt <= bad_cnt + CNT_W'(1);
            end
        end
    end

    // End-of-trace state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // End-of-trace next state: stop intake on eof, finish once empty.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (in_eof) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_next == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_DONE;
            default:  state_next = ST_RUN;
        endcase
    end

endmodule
